// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the main-memory port arbiter.
//   state_t    : burst sequencer states
//   owner_t    : which cache currently owns the memory port
//   line_align : clears the byte-in-line offset bits of an address
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

    // Widest address the alignment helper handles; the top casts into and out of it.
    localparam int MAX_ADDR_W = 64;

    function automatic logic [MAX_ADDR_W-1:0] line_align(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           off_bits
    );
        logic [MAX_ADDR_W-1:0] mask;
        mask = ~((64'd1 << off_bits) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational two-way requester pick for the memory port.
//   ic_req      in  : icache request, already masked by a same-cycle kill
//   dc_req      in  : dcache request
//   last_owner  in  : owner of the most recently completed transfer
//   grant_vld   out : at least one requester present
//   grant_owner out : chosen owner; on a tie the one that did not go last wins
module arb_pick
    import arb_pkg::*;
(
    input  logic   ic_req,
    input  logic   dc_req,
    input  owner_t last_owner,
    output logic   grant_vld,
    output owner_t grant_owner
);

    always_comb begin
        grant_vld   = ic_req | dc_req;
        grant_owner = OWN_IC;
        if (ic_req && dc_req) begin
            grant_owner = (last_owner == OWN_IC) ? OWN_DC : OWN_IC;
        end else if (dc_req) begin
            grant_owner = OWN_DC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between icache refills and dcache
// refills/writebacks. Each transfer is one burst of LINE_BEATS 64-bit beats.
// Ports:
//   CLK, reset_n                         clock, async active-low reset
//   ic_req/ic_addr/ic_kill               icache refill request and redirect kill
//   ic_rvalid/ic_rdata/ic_done           icache beat return and completion pulse
//   dc_req/dc_we/dc_addr/dc_wdata        dcache request, direction, address, write data
//   dc_wready/dc_rvalid/dc_rdata/dc_done dcache beat handshake and completion pulse
//   mem_req/mem_we/mem_addr/mem_gnt      burst request handshake to memory
//   mem_wdata/mem_wready                 write beat path
//   mem_rvalid/mem_rdata                 read beat path
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 64
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_kill,
    output logic              ic_rvalid,
    output logic [63:0]       ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [63:0]       dc_wdata,
    output logic              dc_wready,
    output logic              dc_rvalid,
    output logic [63:0]       dc_rdata,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    output logic [63:0]       mem_wdata,
    input  logic              mem_wready,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    localparam int LINE_OFF_BITS = $clog2(LINE_BEATS * 8);
    localparam int CNT_W         = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, last_owner_q;
    logic              we_q;
    logic              killed_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [ADDR_W-1:0] addr_q;

    logic              ic_req_eff;
    logic              grant_vld;
    owner_t            grant_owner;
    logic              beat;
    logic              ic_kill_hit;
    logic [ADDR_W-1:0] sel_addr;

    // A kill in IDLE removes the icache from arbitration for that cycle.
    assign ic_req_eff  = ic_req & ~ic_kill;
    assign ic_kill_hit = ic_kill & (owner_q == OWN_IC);
    assign sel_addr    = (grant_owner == OWN_IC) ? ic_addr : dc_addr;

    arb_pick u_pick (
        .ic_req      (ic_req_eff),
        .dc_req      (dc_req),
        .last_owner  (last_owner_q),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat      = 1'b0;
        ic_rvalid = 1'b0;
        ic_rdata  = '0;
        ic_done   = 1'b0;
        dc_wready = 1'b0;
        dc_rvalid = 1'b0;
        dc_rdata  = '0;
        dc_done   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = addr_q;
                if (mem_gnt) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                mem_we = we_q;
                if (we_q) begin
                    beat      = mem_wready;
                    dc_wready = mem_wready;
                    mem_wdata = dc_wdata;
                end else begin
                    beat = mem_rvalid;
                    if (owner_q == OWN_IC) begin
                        // A killed refill still drains from memory but is hidden from fetch.
                        ic_rvalid = mem_rvalid & ~killed_q & ~ic_kill;
                        ic_rdata  = ic_rvalid ? mem_rdata : '0;
                    end else begin
                        dc_rvalid = mem_rvalid;
                        dc_rdata  = mem_rvalid ? mem_rdata : '0;
                    end
                end
                if (beat && (beat_cnt_q == LAST_BEAT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ic_done = (owner_q == OWN_IC) & ~killed_q;
                dc_done = (owner_q == OWN_DC);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            owner_q      <= OWN_IC;
            last_owner_q <= OWN_DC;
            we_q         <= 1'b0;
            killed_q     <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q  <= grant_owner;
                        we_q     <= (grant_owner == OWN_DC) & dc_we;
                        killed_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        beat_cnt_q <= '0;
                    end
                    if (ic_kill_hit) begin
                        killed_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                    if (ic_kill_hit) begin
                        killed_q <= 1'b1;
                    end
                end
                DONE: begin
                    last_owner_q <= owner_q;
                    killed_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Burst address is data only; it is never observed outside REQ, so it needs no reset.
    always_ff @(posedge CLK) begin
        if ((state_q == IDLE) && grant_vld) begin
            addr_q <= ADDR_W'(line_align(MAX_ADDR_W'(sel_addr), LINE_OFF_BITS));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with LINE_BEATS=4.
// Stimulus pushes the expected event stream; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int LINE_BEATS = 4;
    localparam int ADDR_W     = 64;

    localparam int EV_BURST   = 0;
    localparam int EV_IC_BEAT = 1;
    localparam int EV_DC_BEAT = 2;
    localparam int EV_WR_BEAT = 3;
    localparam int EV_IC_DONE = 4;
    localparam int EV_DC_DONE = 5;

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic        we;
    } ev_t;

    logic              CLK;
    logic              reset_n;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_kill;
    logic              ic_rvalid;
    logic [63:0]       ic_rdata;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [63:0]       dc_wdata;
    logic              dc_wready;
    logic              dc_rvalid;
    logic [63:0]       dc_rdata;
    logic              dc_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [63:0]       mem_wdata;
    logic              mem_wready;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    bit  ab;

    mem_port_arbiter #(.LINE_BEATS(LINE_BEATS), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_kill    (ic_kill),
        .ic_rvalid  (ic_rvalid),
        .ic_rdata   (ic_rdata),
        .ic_done    (ic_done),
        .dc_req     (dc_req),
        .dc_we      (dc_we),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_wready  (dc_wready),
        .dc_rvalid  (dc_rvalid),
        .dc_rdata   (dc_rdata),
        .dc_done    (dc_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic any_out();
        return |{ic_rvalid, ic_rdata, ic_done, dc_wready, dc_rvalid, dc_rdata, dc_done,
                 mem_req, mem_we, mem_addr, mem_wdata};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] data, input logic we);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.we   = we;
        sb.push_back(e);
    endtask

    // owner: 0 = icache, 1 = dcache
    task automatic push_burst(input int owner, input logic we, input logic [63:0] addr,
                              input logic [63:0] dbase, input int nbeats, input bit done);
        int bk;
        push(EV_BURST, addr, we);
        bk = (owner == 0) ? EV_IC_BEAT : (we ? EV_WR_BEAT : EV_DC_BEAT);
        for (int b = 0; b < nbeats; b++) push(bk, dbase + 64'(b), 1'b0);
        if (done) push((owner == 0) ? EV_IC_DONE : EV_DC_DONE, 64'd0, 1'b0);
    endtask

    task automatic sb_check(input int kind, input logic [63:0] data, input logic we);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got kind=%0d data=%h we=%0d expected no event at %0t",
                     kind, data, we, $time);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.data !== data || e.we !== we) begin
                errors++;
                $display("FAIL sb_event got kind=%0d data=%h we=%0d expected kind=%0d data=%h we=%0d at %0t",
                         kind, data, we, e.kind, e.data, e.we, $time);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (mem_req && mem_gnt) sb_check(EV_BURST, mem_addr, mem_we);
        if (ic_rvalid)          sb_check(EV_IC_BEAT, ic_rdata, 1'b0);
        if (dc_rvalid)          sb_check(EV_DC_BEAT, dc_rdata, 1'b0);
        if (dc_wready)          sb_check(EV_WR_BEAT, mem_wdata, 1'b0);
        if (ic_done)            sb_check(EV_IC_DONE, 64'd0, 1'b0);
        if (dc_done)            sb_check(EV_DC_DONE, 64'd0, 1'b0);
    end

    // Memory-side responder. Waits for mem_req, optionally withholds the grant,
    // then delivers LINE_BEATS beats. kill_at/reset_at inject events before that beat.
    task automatic mem_serve(input logic exp_we, input logic [63:0] exp_addr,
                             input logic [63:0] dbase, input int gnt_delay, input int gap,
                             input int kill_at, input int reset_at, input bit stray,
                             output bit aborted);
        int t;
        t = 0;
        aborted = 1'b0;
        while (mem_req !== 1'b1 && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        if (mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL mem_req_timeout got mem_req=%b expected 1 within 50 cycles", mem_req);
            aborted = 1'b1;
            return;
        end
        if (exp_we) dc_wdata = dbase;
        for (int i = 0; i < gnt_delay; i++) begin
            mem_rvalid = stray;
            mem_wready = stray;
            chk("hold_mem_req", 64'(mem_req), 64'd1);
            chk("hold_mem_addr", mem_addr, exp_addr);
            chk("hold_mem_we", 64'(mem_we), 64'(exp_we));
            @(posedge CLK); #1;
        end
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;
        mem_gnt = 1'b1;
        @(posedge CLK); #1;
        mem_gnt = 1'b0;
        for (int b = 0; b < LINE_BEATS; b++) begin
            repeat (gap) begin
                @(posedge CLK); #1;
            end
            if (b == reset_at) begin
                mem_rvalid = 1'b1;
                mem_rdata  = dbase + 64'(b);
                reset_n    = 1'b0;
                #1;
                chk("reset_mid_burst_outputs", 64'(any_out()), 64'd0);
                mem_rvalid = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (b == kill_at) begin
                ic_kill = 1'b1;
                ic_req  = 1'b0;
            end
            if (exp_we) begin
                mem_wready = 1'b1;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = dbase + 64'(b);
            end
            @(posedge CLK); #1;
            mem_wready = 1'b0;
            mem_rvalid = 1'b0;
            ic_kill    = 1'b0;
            if (exp_we) dc_wdata = dbase + 64'(b + 1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ic_req = 1'b0; ic_addr = '0; ic_kill = 1'b0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = 64'h5555;
        mem_gnt = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h1234;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 64'(any_out()), 64'd0);
        reset_n = 1'b1;
        @(posedge CLK); #1;
        chk("idle_outputs", 64'(any_out()), 64'd0);

        // Simultaneous requests right after reset: IC, DC, IC, then DC alone.
        push_burst(0, 1'b0, 64'h4000, 64'h100, 4, 1);
        push_burst(1, 1'b0, 64'h3000, 64'h200, 4, 1);
        push_burst(0, 1'b0, 64'h4000, 64'h300, 4, 1);
        push_burst(1, 1'b0, 64'h3000, 64'h400, 4, 1);
        ic_req = 1'b1; ic_addr = 64'h4010;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h3008;
        mem_serve(1'b0, 64'h4000, 64'h100, 1, 0, -1, -1, 1'b0, ab);
        mem_serve(1'b0, 64'h3000, 64'h200, 1, 0, -1, -1, 1'b0, ab);
        mem_serve(1'b0, 64'h4000, 64'h300, 1, 0, -1, -1, 1'b0, ab);
        @(posedge CLK); #1;
        ic_req = 1'b0;
        mem_serve(1'b0, 64'h3000, 64'h400, 1, 0, -1, -1, 1'b0, ab);
        @(posedge CLK); #1;
        dc_req = 1'b0;
        @(posedge CLK); #1;

        // Icache refill, grant after 2 cycles.
        push_burst(0, 1'b0, 64'h1020, 64'h1000, 4, 1);
        ic_addr = 64'h1038; ic_req = 1'b1;
        @(posedge CLK); #1;
        chk("ic_req_latency", 64'(mem_req), 64'd1);
        mem_serve(1'b0, 64'h1020, 64'h1000, 2, 0, -1, -1, 1'b0, ab);
        chk("ic_done_timing", 64'(ic_done), 64'd1);
        chk("dc_idle_during_ic", 64'({dc_rvalid, dc_wready, dc_done}), 64'd0);
        @(posedge CLK); #1;
        ic_req = 1'b0;
        @(posedge CLK); #1;

        // Dcache writeback, wready every other cycle.
        push_burst(1, 1'b1, 64'h2000, 64'hA000, 4, 1);
        dc_we = 1'b1; dc_addr = 64'h2000; dc_req = 1'b1;
        mem_serve(1'b1, 64'h2000, 64'hA000, 1, 1, -1, -1, 1'b0, ab);
        chk("dc_done_wb", 64'(dc_done), 64'd1);
        @(posedge CLK); #1;
        dc_req = 1'b0; dc_we = 1'b0;
        @(posedge CLK); #1;

        // Grant withheld 10 cycles with stray beat strobes in REQ.
        push_burst(1, 1'b0, 64'h7FE0, 64'hB000, 4, 1);
        dc_addr = 64'h7FF8; dc_req = 1'b1;
        mem_serve(1'b0, 64'h7FE0, 64'hB000, 10, 0, -1, -1, 1'b1, ab);
        chk("dc_done_withheld", 64'(dc_done), 64'd1);
        @(posedge CLK); #1;
        dc_req = 1'b0;
        @(posedge CLK); #1;

        // Kill the icache refill before beat 2; pending dcache refill goes next.
        push_burst(0, 1'b0, 64'h5000, 64'hC000, 2, 0);
        push_burst(1, 1'b0, 64'h6000, 64'hD000, 4, 1);
        ic_addr = 64'h5008; ic_req = 1'b1;
        dc_addr = 64'h6000; dc_we = 1'b0; dc_req = 1'b1;
        mem_serve(1'b0, 64'h5000, 64'hC000, 0, 0, 2, -1, 1'b0, ab);
        chk("kill_no_done", 64'(ic_done), 64'd0);
        mem_serve(1'b0, 64'h6000, 64'hD000, 0, 0, -1, -1, 1'b0, ab);
        @(posedge CLK); #1;
        dc_req = 1'b0;
        @(posedge CLK); #1;

        // Reset during beat 2, then a clean refill.
        push_burst(0, 1'b0, 64'h8040, 64'hE000, 2, 0);
        ic_addr = 64'h8040; ic_req = 1'b1;
        mem_serve(1'b0, 64'h8040, 64'hE000, 0, 0, -1, 2, 1'b0, ab);
        @(posedge CLK); #1;
        ic_req = 1'b0;
        chk("reset_held_outputs", 64'(any_out()), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        reset_n = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset_outputs", 64'(any_out()), 64'd0);
        push_burst(0, 1'b0, 64'h8040, 64'hF000, 4, 1);
        ic_req = 1'b1;
        mem_serve(1'b0, 64'h8040, 64'hF000, 1, 0, -1, -1, 1'b0, ab);
        chk("ic_done_after_reset", 64'(ic_done), 64'd1);
        @(posedge CLK); #1;
        ic_req = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
